// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction-memory arbiter.
//   DEPTH        default memory depth in 32-bit words (power of two)
//   IDX_W        word-index width, log2(DEPTH)
//   RD_OOR_DATA  data returned for an out-of-range read
//   arb_state_e  arbiter FSM states
//   owner_e      owner of the registered read response
package imem_pkg;

    localparam int unsigned DEPTH       = 32;
    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] RD_OOR_DATA = 32'h0;

    typedef enum logic {
        ARB,
        LOCK
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_L
    } owner_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: bundle of the fetch, loader and memory-port signals around imem_arbiter.
//   fetch : f_req, f_addr -> f_gnt, f_rvalid, f_rdata
//   loader: l_req, l_we, l_lock, l_addr, l_wdata -> l_gnt, l_rvalid, l_rdata
//   memory: mem_en, mem_we, mem_idx, mem_wdata -> mem_rdata (combinational from mem_idx)
// Modports: slave (the arbiter), master (requesters and memory model).
interface imem_arbiter_if #(
    parameter int unsigned DEPTH = imem_pkg::DEPTH
);
    import imem_pkg::*;

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic            f_req;
    logic [31:0]     f_addr;
    logic            f_gnt;
    logic            f_rvalid;
    logic [31:0]     f_rdata;

    logic            l_req;
    logic            l_we;
    logic            l_lock;
    logic [31:0]     l_addr;
    logic [31:0]     l_wdata;
    logic            l_gnt;
    logic            l_rvalid;
    logic [31:0]     l_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [IdxW-1:0] mem_idx;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
        output mem_en, mem_we, mem_idx, mem_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
        input  mem_en, mem_we, mem_idx, mem_wdata
    );

endinterface

// File: rtl/imem_starve_cnt.sv
// imem_starve_cnt: saturating count of consecutive loader denials.
//   clk, rst_n : clock, async active-low reset
//   inc        : loader requested and was denied this cycle
//   clr        : loader granted this cycle (wins over inc)
//   hit        : count has reached STARVE_MAX
module imem_starve_cnt #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    import imem_pkg::*;

    localparam int unsigned     CntW   = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == CntMax);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one word-organised instruction-memory port between the fetch stage
// (read-only) and the program loader (read/write). Byte addresses become word indices;
// read data returns one cycle after grant with a per-requester valid.
//   clk, rst_n : clock, async active-low reset (grants and strobes forced low while asserted)
//   bus        : imem_arbiter_if.slave carrying fetch, loader and memory-port signals
// Build option: define IMEM_ARB_LOADER_EN for the loader path (lock, starvation guard).
// Without it the loader inputs are ignored, loader outputs are 0 and fetch always wins.
module imem_arbiter #(
    parameter int unsigned DEPTH      = imem_pkg::DEPTH,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_arbiter_if.slave bus
);
    import imem_pkg::*;

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic        f_gnt;
    logic        l_gnt;
    logic        gnt_any;
    logic        acc_we;
    logic        acc_oor;
    logic [31:0] acc_addr;

    owner_e      owner_q, owner_d;
    logic [31:0] rdata_q, rdata_d;

    // Any set bit above the word index puts the access outside the array.
    function automatic logic addr_oor(input logic [31:0] addr);
        return |(addr >> (IdxW + 2));
    endfunction

`ifdef IMEM_ARB_LOADER_EN
    arb_state_e state_q, state_d;
    logic       starve_inc;
    logic       starve_hit;

    imem_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (starve_inc),
        .clr  (l_gnt),
        .hit  (starve_hit)
    );

    always_comb begin
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        starve_inc = 1'b0;
        state_d    = state_q;
        if (rst_n) begin
            unique case (state_q)
                ARB: begin
                    if (bus.l_req && (!bus.f_req || starve_hit)) begin
                        l_gnt = 1'b1;
                    end else begin
                        f_gnt = bus.f_req;
                    end
                    starve_inc = bus.l_req && !l_gnt;
                    if (l_gnt && bus.l_lock) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    l_gnt = bus.l_req;
                    // l_lock is sampled every cycle in LOCK, granted or not.
                    if (!bus.l_lock) begin
                        state_d = ARB;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    assign acc_addr = l_gnt ? bus.l_addr : bus.f_addr;
    assign acc_we   = l_gnt && bus.l_we;
`else
    logic unused_loader;

    assign f_gnt         = rst_n && bus.f_req;
    assign l_gnt         = 1'b0;
    assign acc_addr      = bus.f_addr;
    assign acc_we        = 1'b0;
    assign unused_loader = ^{bus.l_req, bus.l_we, bus.l_lock, bus.l_addr, bus.l_wdata};
`endif

    // Byte offset within the word is ignored.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^acc_addr[1:0];

    assign gnt_any       = f_gnt || l_gnt;
    assign acc_oor       = addr_oor(acc_addr);

    assign bus.f_gnt     = f_gnt;
    assign bus.l_gnt     = l_gnt;
    assign bus.mem_en    = gnt_any && !acc_oor;
    assign bus.mem_we    = acc_we && !acc_oor;
    assign bus.mem_idx   = gnt_any ? acc_addr[2 +: IdxW] : '0;
    assign bus.mem_wdata = acc_we ? bus.l_wdata : '0;

    // One shared response register; owner_q steers it to the requester that was granted.
    always_comb begin
        owner_d = OWN_NONE;
        rdata_d = rdata_q;
        if (f_gnt) begin
            owner_d = OWN_F;
        end else if (l_gnt && !acc_we) begin
            owner_d = OWN_L;
        end
        if (owner_d != OWN_NONE) begin
            rdata_d = acc_oor ? RD_OOR_DATA : bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
            rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.f_rvalid = (owner_q == OWN_F);
    assign bus.l_rvalid = (owner_q == OWN_L);
    assign bus.f_rdata  = (owner_q == OWN_F) ? rdata_q : '0;
    assign bus.l_rdata  = (owner_q == OWN_L) ? rdata_q : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random stimulus for imem_arbiter, checked against a
// cycle-level reference of the arbitration rules and a shadow copy of the memory.
// Works with or without IMEM_ARB_LOADER_EN.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int unsigned DEPTH      = 32;
    localparam int unsigned STARVE_MAX = 4;
`ifdef IMEM_ARB_LOADER_EN
    localparam bit LoaderEn = 1'b1;
`else
    localparam bit LoaderEn = 1'b0;
`endif

    logic clk;
    logic rst_n;

    imem_arbiter_if #(.DEPTH(DEPTH)) bus ();

    imem_arbiter #(
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory array with a backdoor port for preloading.
    logic [31:0] mem [DEPTH];
    logic        bd_we;
    logic [4:0]  bd_idx;
    logic [31:0] bd_data;

    assign bus.mem_rdata = mem[bus.mem_idx];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_idx] <= bus.mem_wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    bit          m_locked   = 1'b0;
    int unsigned m_denied   = 0;
    bit          m_pend_f   = 1'b0;
    bit          m_pend_l   = 1'b0;
    logic [31:0] m_pend_dat = '0;

    // Last observed values, for test-plan spot checks.
    logic        obs_fg, obs_lg, obs_fv, obs_en, obs_we;
    logic [31:0] obs_fd;
    logic [4:0]  obs_idx;

    function automatic logic [31:0] pat(input int unsigned i);
        return 32'h1000_0000 + i * 32'h0001_0011;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model by one edge.
    task automatic step(input bit rst, input bit fr, input logic [31:0] fa,
                        input bit lr, input bit lwe, input bit llk,
                        input logic [31:0] la, input logic [31:0] lwd);
        bit          e_fg, e_lg, e_any, e_oor, e_we;
        logic [31:0] a;
        int unsigned e_idx;
        @(negedge clk);
        rst_n       = rst;
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.l_req   = lr;
        bus.l_we    = lwe;
        bus.l_lock  = llk;
        bus.l_addr  = la;
        bus.l_wdata = lwd;
        if (!rst) begin
            m_pend_f = 1'b0;
            m_pend_l = 1'b0;
        end
        #1;
        obs_fg  = bus.f_gnt;
        obs_lg  = bus.l_gnt;
        obs_fv  = bus.f_rvalid;
        obs_fd  = bus.f_rdata;
        obs_en  = bus.mem_en;
        obs_we  = bus.mem_we;
        obs_idx = bus.mem_idx;

        chk("f_rvalid", bus.f_rvalid, m_pend_f);
        chk("l_rvalid", bus.l_rvalid, m_pend_l);
        if (m_pend_f) chk("f_rdata", bus.f_rdata, m_pend_dat);
        if (m_pend_l) chk("l_rdata", bus.l_rdata, m_pend_dat);
        if (!rst) begin
            chk("rst_f_rdata", bus.f_rdata, 32'h0);
            chk("rst_l_rdata", bus.l_rdata, 32'h0);
        end

        e_fg = 1'b0;
        e_lg = 1'b0;
        if (rst) begin
            if (!LoaderEn) e_fg = fr;
            else if (m_locked) e_lg = lr;
            else if (lr && (!fr || m_denied == STARVE_MAX)) e_lg = 1'b1;
            else e_fg = fr;
        end
        e_any = e_fg || e_lg;
        a     = e_lg ? la : fa;
        e_oor = (a >= DEPTH * 4);
        e_idx = (a / 4) % DEPTH;
        e_we  = e_lg && lwe && !e_oor;

        chk("f_gnt", bus.f_gnt, e_fg);
        chk("l_gnt", bus.l_gnt, e_lg);
        chk("mem_en", bus.mem_en, e_any && !e_oor);
        chk("mem_we", bus.mem_we, e_we);
        if (e_any && !e_oor) chk("mem_idx", 32'(bus.mem_idx), e_idx);
        if (!e_any) begin
            chk("idle_mem_idx", 32'(bus.mem_idx), 32'h0);
            chk("idle_mem_wdata", bus.mem_wdata, 32'h0);
        end
        if (e_we) chk("mem_wdata", bus.mem_wdata, lwd);

        if (!rst) begin
            m_locked = 1'b0;
            m_denied = 0;
        end else begin
            m_pend_f   = e_fg;
            m_pend_l   = e_lg && !lwe;
            m_pend_dat = e_oor ? 32'h0 : ref_mem[e_idx];
            if (e_we) ref_mem[e_idx] = lwd;
            if (e_lg) m_denied = 0;
            else if (lr && !m_locked && m_denied < STARVE_MAX) m_denied++;
            if (m_locked) m_locked = llk;
            else m_locked = e_lg && llk;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] fa);
        step(1'b1, 1'b1, fa, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        bit          exp_l;
        bit          rr, fr, lr, lwe, llk;
        logic [31:0] fa, la, lwd;

        rst_n       = 1'b0;
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.l_req   = 1'b0;
        bus.l_we    = 1'b0;
        bus.l_lock  = 1'b0;
        bus.l_addr  = '0;
        bus.l_wdata = '0;
        bd_we       = 1'b0;
        bd_idx      = '0;
        bd_data     = '0;

        // Preload memory and shadow while in reset.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            bd_we      = 1'b1;
            bd_idx     = 5'(i);
            bd_data    = pat(i);
            ref_mem[i] = pat(i);
        end
        @(negedge clk);
        bd_we = 1'b0;

        // Reset holds every output low even with requests present.
        step(1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
        idle();

        // Fetch of 0x4: same-cycle grant, mem[1] one cycle later.
        fetch(32'h4);
        chk("tp_fetch_gnt", obs_fg, 1'b1);
        idle();
        chk("tp_fetch_rvalid", obs_fv, 1'b1);
        chk("tp_fetch_rdata", obs_fd, pat(1));

        // Loader write of 0x8, then fetch it back.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8, 32'hDEAD_BEEF);
        chk("tp_wr_mem_we", obs_we, LoaderEn);
        chk("tp_wr_mem_idx", 32'(obs_idx), LoaderEn ? 32'd2 : 32'd0);
        fetch(32'h8);
        idle();
        chk("tp_wr_readback", obs_fd, LoaderEn ? 32'hDEAD_BEEF : pat(2));

        // Starvation: clear the counter with a lone loader read, then contend for 10 cycles.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0);
            exp_l = LoaderEn && (i == 4 || i == 9);
            chk($sformatf("tp_starve_l_gnt_%0d", i), obs_lg, exp_l);
            chk($sformatf("tp_starve_f_gnt_%0d", i), obs_fg, !exp_l);
        end
        idle();

        // Lock: three locked write grants, release, fetch resumes the cycle after.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC, 32'hCAFE_0001);
        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'hC, 32'hCAFE_0002);
        chk("tp_lock_f_gnt_1", obs_fg, !LoaderEn);
        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'hC, 32'hCAFE_0003);
        chk("tp_lock_f_gnt_2", obs_fg, !LoaderEn);
        step(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 32'hC, 32'hCAFE_0004);
        chk("tp_lock_f_gnt_rel", obs_fg, !LoaderEn);
        fetch(32'h4);
        chk("tp_lock_f_gnt_after", obs_fg, 1'b1);
        idle();

        // Out of range: granted, no strobe, reads 0, writes dropped.
        fetch(32'h80);
        chk("tp_oor_gnt", obs_fg, 1'b1);
        chk("tp_oor_mem_en", obs_en, 1'b0);
        idle();
        chk("tp_oor_rvalid", obs_fv, 1'b1);
        chk("tp_oor_rdata", obs_fd, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h80, 32'hBAD0_BAD0);
        chk("tp_oor_mem_we", obs_we, 1'b0);
        fetch(32'h0);
        idle();
        chk("tp_oor_unchanged", obs_fd, pat(0));

        // Reset in the cycle after a fetch grant.
        fetch(32'h10);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("tp_rst_rvalid", obs_fv, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk("tp_rst_rvalid_after", obs_fv, 1'b0);
        idle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rr  = ($urandom_range(0, 59) != 0);
            fr  = ($urandom_range(0, 2) != 0);
            lr  = ($urandom_range(0, 1) != 0);
            lwe = ($urandom_range(0, 1) != 0);
            llk = ($urandom_range(0, 3) == 0);
            fa  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h80)
                                              : 32'($urandom_range(0, DEPTH * 4 - 1));
            la  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h80)
                                              : 32'($urandom_range(0, DEPTH * 4 - 1));
            lwd = $urandom;
            step(rr, fr, fa, lr, lwe, llk, la, lwd);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
